// File: rtl/move_checker.sv
// Connect-four move engine: drops a piece into the selected column, scans the
// four line directions through the landing cell, and reports win/tie/next turn.
module move_checker #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] current_state,
    input  logic       col_valid,
    input  logic [2:0] col_sel,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] in_game_status,
    output logic       player_turn,
    output logic       busy,
    output logic       move_done,
    output logic       move_err,
    output logic [1:0] rd_cell
);

    localparam int         HW   = $clog2(ROWS + 1);
    localparam logic [5:0] FULL = 6'(ROWS * COLS);

    typedef enum logic [1:0] {IDLE, DROP, CHECK, REPORT} state_e;

    state_e        state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [1:0]    board_q [ROWS][COLS];
    logic [HW-1:0] height_q [COLS];
    logic [5:0]    moves_q;
    logic [2:0]    col_q;
    logic [HW-1:0] row_q;
    logic          mover_q;
    logic          win_q, win_d;
    logic [1:0]    status_q, status_d;
    logic          turn_q, turn_d;
    logic          done_q, err_q;

    logic          playing, new_game, col_ok, accept, reject;
    logic [HW-1:0] sel_height;
    logic [1:0]    code;
    int            dr, dc, run, r0, c0;
    logic          fwd, bwd, dir_win;

    assign playing  = (current_state == 2'b01) || (current_state == 2'b10);
    assign new_game = (current_state == 2'b00);
    assign code     = mover_q ? 2'b10 : 2'b01;

    // Out-of-range coordinates read as empty, which bounds every run at the edges.
    function automatic logic [1:0] cell_at(input int r, input int c);
        logic [1:0] v;
        v = '0;
        for (int unsigned rr = 0; rr < ROWS; rr++)
            for (int unsigned cc = 0; cc < COLS; cc++)
                if (r == int'(rr) && c == int'(cc)) v = board_q[rr][cc];
        return v;
    endfunction

    always_comb begin
        col_ok     = 1'b0;
        sel_height = '0;
        for (int unsigned c = 0; c < COLS; c++)
            if (32'(col_sel) == c) begin
                col_ok     = 1'b1;
                sel_height = height_q[c];
            end
    end

    assign accept = (state_q == IDLE) && col_valid && playing && col_ok && (32'(sel_height) < ROWS);
    assign reject = (state_q == IDLE) && col_valid && playing && !(col_ok && (32'(sel_height) < ROWS));

    always_comb begin
        rd_cell = '0;
        for (int unsigned rr = 0; rr < ROWS; rr++)
            for (int unsigned cc = 0; cc < COLS; cc++)
                if (32'(rd_row) == rr && 32'(rd_col) == cc) rd_cell = board_q[rr][cc];
    end

    // One direction per CHECK cycle: walk outward both ways from the landing cell.
    always_comb begin
        dr = 0;
        dc = 1;
        case (step_q)
            2'd0: begin dr = 0; dc = 1;  end
            2'd1: begin dr = 1; dc = 0;  end
            2'd2: begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        r0  = int'(row_q);
        c0  = int'(col_q);
        run = 1;
        fwd = 1'b1;
        bwd = 1'b1;
        for (int unsigned k = 1; k < WIN_LEN; k++) begin
            if (fwd && cell_at(r0 + int'(k) * dr, c0 + int'(k) * dc) == code) run = run + 1;
            else fwd = 1'b0;
            if (bwd && cell_at(r0 - int'(k) * dr, c0 - int'(k) * dc) == code) run = run + 1;
            else bwd = 1'b0;
        end
        dir_win = (run >= WIN_LEN);
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        win_d    = win_q;
        status_d = status_q;
        turn_d   = turn_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = DROP;
                win_d   = 1'b0;
            end
            DROP: begin
                state_d = CHECK;
                step_d  = '0;
            end
            CHECK: begin
                step_d = step_q + 2'd1;
                if (dir_win) win_d = 1'b1;
                if (step_q == 2'd3) state_d = REPORT;
            end
            REPORT: begin
                state_d = IDLE;
                if (win_q) status_d = mover_q ? 2'b10 : 2'b01;
                else if (moves_q == FULL) status_d = 2'b11;
                else begin
                    status_d = 2'b00;
                    turn_d   = ~turn_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_game) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            win_q    <= 1'b0;
            status_q <= '0;
            turn_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            moves_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            mover_q  <= 1'b0;
            for (int unsigned c = 0; c < COLS; c++) begin
                height_q[c] <= '0;
                for (int unsigned r = 0; r < ROWS; r++) board_q[r][c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            win_q    <= win_d;
            status_q <= status_d;
            turn_q   <= turn_d;
            done_q   <= (state_q == REPORT);
            err_q    <= reject;
            if (accept) begin
                col_q   <= col_sel;
                mover_q <= turn_q;
            end
            if (state_q == DROP) begin
                board_q[height_q[col_q]][col_q] <= code;
                height_q[col_q]                 <= height_q[col_q] + 1'b1;
                row_q                           <= height_q[col_q];
                moves_q                         <= moves_q + 6'd1;
            end
            if (new_game) begin
                status_q <= '0;
                turn_q   <= 1'b0;
                done_q   <= 1'b0;
                err_q    <= 1'b0;
                moves_q  <= '0;
                for (int unsigned c = 0; c < COLS; c++) begin
                    height_q[c] <= '0;
                    for (int unsigned r = 0; r < ROWS; r++) board_q[r][c] <= '0;
                end
            end
        end
    end

    assign in_game_status = status_q;
    assign player_turn    = turn_q;
    assign busy           = (state_q != IDLE);
    assign move_done      = done_q;
    assign move_err       = err_q;

endmodule

// File: tb/tb_move_checker.sv
// Bench for move_checker: directed and random games compared against a
// whole-board reference model of the game rules.
module tb_move_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] current_state;
    logic       col_valid;
    logic [2:0] col_sel, rd_row, rd_col;
    logic [1:0] in_game_status, rd_cell;
    logic       player_turn, busy, move_done, move_err;

    always #5 clk = ~clk;

    move_checker #(.ROWS(6), .COLS(7), .WIN_LEN(4)) dut (
        .clk(clk), .reset(reset), .current_state(current_state),
        .col_valid(col_valid), .col_sel(col_sel), .rd_row(rd_row), .rd_col(rd_col),
        .in_game_status(in_game_status), .player_turn(player_turn), .busy(busy),
        .move_done(move_done), .move_err(move_err), .rd_cell(rd_cell)
    );

    int checks = 0;
    int errors = 0;
    int mb [6][7];
    int mh [7];
    int mcount, mturn, mstatus;

    int tie_seq  [42] = '{0,0,0,0,0,0, 1,1,1,1,1,1, 4, 2,2,2,2,2,2, 3,3,3,3,3,3,
                          4,4,4,4,4, 5, 6,6,6,6,6,6, 5,5,5,5,5};
    int anti_seq [42] = '{0,0,0,0,0,0, 1,1,1,1,1,1, 4,4,4,4, 5,5,5,5,5, 2,2,2,2,2,2,
                          3,3,3,3,3, 5, 6,6,6,6, 4, 6, 4, 6, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit has_four(input int p);
        int dr_t [4] = '{0, 1, 1, 1};
        int dc_t [4] = '{1, 0, 1, -1};
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        int rr = r + k * dr_t[d];
                        int cc = c + k * dc_t[d];
                        if (rr < 0 || rr > 5 || cc < 0 || cc > 6) ok = 1'b0;
                        else if (mb[rr][cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) mb[r][c] = 0;
        for (int c = 0; c < 7; c++) mh[c] = 0;
        mcount = 0; mturn = 0; mstatus = 0;
    endtask

    task automatic model_move(input int c);
        int p = mturn + 1;
        mb[mh[c]][c] = p;
        mh[c]++;
        mcount++;
        if (has_four(p)) mstatus = p;
        else if (mcount == 42) mstatus = 3;
        else begin
            mstatus = 0;
            mturn   = 1 - mturn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                rd_row = 3'(r);
                rd_col = 3'(c);
                #1;
                chk($sformatf("%s_rd_cell[%0d][%0d]", tag, r, c), 32'(rd_cell),
                    (r < 6 && c < 7) ? mb[r][c] : 0);
            end
        tick();
    endtask

    task automatic do_move(input int c, input bit poke_busy);
        int n = 0, busy_cnt = 0, err_seen = 0;
        current_state = (mturn != 0) ? 2'b10 : 2'b01;
        col_sel   = 3'(c);
        col_valid = 1'b1;
        tick();
        col_valid = 1'b0;
        chk("done_low_after_accept", 32'(move_done), 0);
        while (!move_done && n < 20) begin
            if (busy) busy_cnt++;
            if (move_err) err_seen++;
            if (poke_busy && n == 2) begin
                col_sel   = 3'((c + 1) % 7);
                col_valid = 1'b1;
            end
            tick();
            col_valid = 1'b0;
            n++;
        end
        model_move(c);
        chk("latency", n, 6);
        chk("busy_cycles", busy_cnt, 6);
        chk("no_err_in_move", err_seen, 0);
        chk("busy_at_done", 32'(busy), 0);
        chk("status", 32'(in_game_status), mstatus);
        chk("turn", 32'(player_turn), mturn);
        rd_row = 3'(mh[c] - 1);
        rd_col = 3'(c);
        #1;
        chk("landing_cell", 32'(rd_cell), mb[mh[c] - 1][c]);
    endtask

    task automatic do_err(input int c);
        current_state = (mturn != 0) ? 2'b10 : 2'b01;
        col_sel   = 3'(c);
        col_valid = 1'b1;
        tick();
        col_valid = 1'b0;
        chk("err_pulse", 32'(move_err), 1);
        chk("err_not_busy", 32'(busy), 0);
        tick();
        chk("err_one_cycle", 32'(move_err), 0);
        chk("err_no_done", 32'(move_done), 0);
        chk("err_turn", 32'(player_turn), mturn);
        chk("err_status", 32'(in_game_status), mstatus);
    endtask

    task automatic new_game();
        current_state = 2'b00;
        col_sel   = 3'd3;
        col_valid = 1'b1;
        tick();
        col_valid = 1'b0;
        model_clear();
        chk("ng_err", 32'(move_err), 0);
        chk("ng_busy", 32'(busy), 0);
        chk("ng_status", 32'(in_game_status), 0);
        chk("ng_turn", 32'(player_turn), 0);
        rd_row = 3'd0;
        rd_col = 3'd3;
        #1;
        chk("ng_cell", 32'(rd_cell), 0);
        current_state = 2'b01;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int full_c, guard, sel, rc;
        reset = 1'b1; current_state = 2'b00; col_valid = 1'b0;
        col_sel = '0; rd_row = '0; rd_col = '0;
        model_clear();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(move_done), 0);
        chk("rst_err", 32'(move_err), 0);
        chk("rst_status", 32'(in_game_status), 0);
        chk("rst_turn", 32'(player_turn), 0);
        reset = 1'b0;
        current_state = 2'b01;
        tick();

        do_move(3, 1'b0);
        chk("single_cell_0_3", 32'(rd_cell), 1);
        chk("single_turn", 32'(player_turn), 1);
        new_game();

        for (int i = 0; i < 7; i++) do_move(i % 2, 1'b0);
        chk("vwin_status", 32'(in_game_status), 1);
        chk("vwin_turn", 32'(player_turn), 0);
        new_game();

        for (int i = 0; i < 6; i++) do_move(2, i == 1);
        tick();
        chk("one_done_only", 32'(move_done), 0);
        chk("idle_after_poke", 32'(busy), 0);
        do_err(2);
        check_board("fullcol");
        do_err(7);
        current_state = 2'b11;
        col_sel = 3'd4;
        col_valid = 1'b1;
        tick();
        col_valid = 1'b0;
        chk("end_game_no_err", 32'(move_err), 0);
        chk("end_game_no_busy", 32'(busy), 0);
        tick();
        chk("end_game_no_done", 32'(move_done), 0);
        check_board("endgame");
        new_game();

        for (int i = 0; i < 42; i++) do_move(tie_seq[i], 1'b0);
        chk("tie_status", 32'(in_game_status), 3);
        chk("tie_turn", 32'(player_turn), 1);
        new_game();

        for (int i = 0; i < 42; i++) do_move(anti_seq[i], 1'b0);
        chk("anti_win_status", 32'(in_game_status), 2);
        check_board("anti");
        new_game();

        for (int g = 0; g < 3; g++) begin
            guard = 0;
            while (mstatus == 0 && guard < 80) begin
                guard++;
                rc = int'($urandom_range(9, 0));
                full_c = -1;
                for (int c = 0; c < 7; c++) if (mh[c] == 6) full_c = c;
                if (rc == 0) do_err(7);
                else if (rc == 1 && full_c >= 0) do_err(full_c);
                else begin
                    sel = int'($urandom_range(6, 0));
                    while (mh[sel] >= 6) sel = (sel + 1) % 7;
                    do_move(sel, rc == 2);
                end
            end
            check_board("random");
            new_game();
        end

        do_move(0, 1'b0);
        do_move(1, 1'b0);
        do_move(0, 1'b0);
        current_state = 2'b10;
        col_sel = 3'd4;
        col_valid = 1'b1;
        tick();
        col_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(move_done), 0);
        chk("mid_rst_err", 32'(move_err), 0);
        chk("mid_rst_status", 32'(in_game_status), 0);
        chk("mid_rst_turn", 32'(player_turn), 0);
        model_clear();
        tick();
        reset = 1'b0;
        current_state = 2'b01;
        begin
            int done_seen = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (move_done) done_seen++;
            end
            chk("mid_rst_no_done", done_seen, 0);
        end
        check_board("after_reset");
        do_move(5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_checker.md
MOVE_CHECKER -- requirements
Module: move_checker

Interface
REQ-001 Parameter: ROWS, 6, board height in rows; row 0 is the bottom row.
REQ-002 Parameter: COLS, 7, board width in columns.
REQ-003 Parameter: WIN_LEN, 4, count of contiguous same-player cells that wins.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 current_state  in  2  game FSM state: 00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME.
REQ-007 col_valid  in  1  one-cycle move request strobe.
REQ-008 col_sel  in  3  target column of the move, 0..COLS-1.
REQ-009 rd_row  in  3  display read row address.
REQ-010 rd_col  in  3  display read column address.
REQ-011 in_game_status  out  2  result sent to the game FSM: 00 NEXT_TURN, 01 P1_WIN, 10 P2_WIN, 11 TIE_GAME.
REQ-012 player_turn  out  1  player to move next: 0 = P1, 1 = P2.
REQ-013 busy  out  1  high while a move is being processed.
REQ-014 move_done  out  1  one-cycle pulse when a move has been committed and judged.
REQ-015 move_err  out  1  one-cycle pulse when a move request is rejected.
REQ-016 rd_cell  out  2  combinational read of board[rd_row][rd_col]: 00 empty, 01 P1, 10 P2; reads 00 when the address is out of range.

Function
REQ-017 Internal state SHALL be: board of ROWS x COLS 2-bit cells, a per-column height counter (0..ROWS), and a 6-bit move counter.
REQ-018 The control FSM SHALL have these states: IDLE, DROP, CHECK, REPORT.
REQ-019 In IDLE, the block SHALL accept a request when all of these hold: col_valid=1, current_state is 01 or 10, col_sel<COLS, and height[col_sel]<ROWS.
REQ-020 On acceptance, the block SHALL latch col_sel and the mover (current player_turn), then go to DROP.
REQ-021 In IDLE, col_valid with current_state 01 or 10 and either col_sel>=COLS or a full column SHALL pulse move_err on the next cycle, with no change to board, height, counter, player_turn or in_game_status.
REQ-022 col_valid while current_state is 00 or 11 SHALL be ignored: no move_err, no state change.
REQ-023 col_valid while busy=1 SHALL be ignored: no queuing, no move_err.
REQ-024 DROP (one cycle) SHALL do all of the following:
- write the mover code to board[height][col];
- increment height[col];
- increment the move counter;
- latch the landing row;
- go to CHECK.
REQ-025 CHECK SHALL last exactly 4 cycles, one direction per cycle, in this order: horizontal, vertical, diagonal (+row,+col), anti-diagonal (+row,-col).
REQ-026 Each CHECK cycle SHALL count the run of mover cells through the landing cell along that direction, bounded by board edges, and set a sticky win flag if the run is >= WIN_LEN.
REQ-027 After the 4th CHECK cycle, the FSM SHALL go to REPORT.
REQ-028 REPORT (one cycle) SHALL pulse move_done and set in_game_status as follows:
- win: 01 if the mover is P1, 10 if the mover is P2;
- no win and move counter = ROWS*COLS: 11;
- otherwise: 00, and player_turn toggles.
REQ-029 A win on the final empty cell SHALL report the win, not a tie.
REQ-030 On a win or tie, player_turn SHALL NOT toggle.
REQ-031 After REPORT, the FSM SHALL return to IDLE.
REQ-032 busy SHALL be high exactly in DROP, CHECK and REPORT.
REQ-033 Latency: with the request accepted at edge T, move_done SHALL be high in the cycle following edge T+6 (DROP at T+1, CHECK at T+2..T+5, REPORT at T+6).
REQ-034 in_game_status and player_turn SHALL hold their values between REPORT cycles.
REQ-035 When current_state is 00, board, heights, counter, player_turn and in_game_status SHALL be cleared synchronously (new game), and the FSM SHALL be forced to IDLE.
REQ-036 The block SHALL sustain at most one move per 7 cycles; a back-to-back request is accepted in the cycle after REPORT.

Reset
REQ-037 On reset assertion, the block SHALL immediately set every output and state element as follows:
- board all 00, heights 0, move counter 0;
- FSM IDLE;
- in_game_status 00, player_turn 0;
- busy 0, move_done 0, move_err 0.
REQ-038 Reset asserted mid-move (DROP/CHECK/REPORT) SHALL abort the move with no move_done pulse.

Verification
REQ-039 Single move: current_state=01, col_sel=3 strobe -> busy for 6 cycles; then move_done pulse, rd_cell(0,3)=01, in_game_status=00, player_turn=1.
REQ-040 Vertical win: moves alternate in columns 0,1,0,1,0,1,0 (P1 in col 0) -> on the 7th move_done, in_game_status=01 and player_turn stays 0.
REQ-041 Full column: six moves into column 2, then a 7th to column 2 -> move_err pulse, rd_cell unchanged, player_turn unchanged.
REQ-042 Out-of-range and ignored requests:
- col_sel=7 -> move_err;
- current_state=11 with col_valid -> no response;
- col_valid while busy -> ignored, exactly one move_done.
REQ-043 Tie: 42-move sequence with no four-in-a-row -> final in_game_status=11; a variant whose 42nd move wins on the anti-diagonal -> 01 or 10.
REQ-044 Reset at the 2nd CHECK cycle -> outputs at reset values, no move_done, rd_cell all 00.
